// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232 transmit path: drain FSM states and
// the line-ending characters used by the optional CR/LF expansion.
package rs232_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      GUARD = 2'd2
   } drain_state_e;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/rs232out_fifo_sync_fifo.sv
// Generic synchronous FIFO (module sync_fifo): unreset storage array with
// registered pointers, occupancy counter, full and empty flags.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic [LOG2_DEPTH:0]   level_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] DEPTH_L = (LOG2_DEPTH+1)'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG2_DEPTH:0]   level_q, level_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  do_push, do_pop;

   // A push while full is dropped even if a pop happens in the same cycle.
   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      full_d  = (level_d == DEPTH_L);
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/rs232out_fifo.sv
// Transmit queue between the rs232 bridge and the rs232out serializer.
// Define RS232OUT_FIFO_CRLF_EN to expand each LF into CR followed by LF.
module rs232out_fifo
   import rs232_pkg::*;
#(
   parameter int LOG2_DEPTH = 4
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                in_w,
   input  logic [7:0]          in_d,
   output logic                in_busy,
   output logic                out_we,
   output logic [7:0]          out_d,
   input  logic                out_busy,
   output logic [LOG2_DEPTH:0] level,
   output logic                overflow
);

   drain_state_e state_q, state_d;
   logic [7:0]   head;
   logic [7:0]   tx_byte;
   logic [7:0]   out_d_q;
   logic         fifo_full, fifo_empty;
   logic         pop;
   logic         emit_cr;
   logic         overflow_q;

   sync_fifo #(
      .WIDTH      (8),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .clk     (clock),
      .rst     (rst),
      .push_i  (in_w),
      .pop_i   (pop),
      .wdata_i (in_d),
      .rdata_o (head),
      .level_o (level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef RS232OUT_FIFO_CRLF_EN
   logic cr_flag_q;

   // First visit to an LF head sends CR and leaves the LF queued.
   assign emit_cr = (head == CHAR_LF) && !cr_flag_q;

   always_ff @(posedge clock) begin
      if (rst)                  cr_flag_q <= 1'b0;
      else if (state_q == SEND) cr_flag_q <= emit_cr;
   end
`else
   assign emit_cr = 1'b0;
`endif

   assign tx_byte = emit_cr ? CHAR_CR : head;

   always_ff @(posedge clock) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty && !out_busy) state_d = SEND;
         SEND:    state_d = GUARD;
         GUARD:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_we = (state_q == SEND);
      pop    = (state_q == SEND) && !emit_cr;
   end

   // Byte is captured on entry to SEND so out_d is a clean register output.
   always_ff @(posedge clock) begin
      if (rst)                                    out_d_q <= '0;
      else if (state_q == IDLE && state_d == SEND) out_d_q <= tx_byte;
   end

   always_ff @(posedge clock) begin
      if (rst)                    overflow_q <= 1'b0;
      else if (in_w && fifo_full) overflow_q <= 1'b1;
   end

   assign out_d    = out_d_q;
   assign in_busy  = fifo_full;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_rs232out_fifo.sv
// Directed bench for rs232out_fifo with a simple serializer busy model.
// Honours RS232OUT_FIFO_CRLF_EN for the line-ending expectations.
module tb_rs232out_fifo;

   logic       clock = 1'b0;
   logic       rst;
   logic       in_w;
   logic [7:0] in_d;
   logic       in_busy;
   logic       out_we;
   logic [7:0] out_d;
   logic       out_busy;
   logic [4:0] level;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic busy_force = 1'b0;
   logic busy_clr   = 1'b0;
   int   busy_len   = 0;
   int   busy_cnt   = 0;

   logic [7:0] got_q[$];
   int         pulse_cyc_q[$];
   int         last_pulse = -1000000;
   int         min_gap = 1000000;

   rs232out_fifo #(.LOG2_DEPTH(4)) dut (
      .clock    (clock),
      .rst      (rst),
      .in_w     (in_w),
      .in_d     (in_d),
      .in_busy  (in_busy),
      .out_we   (out_we),
      .out_d    (out_d),
      .out_busy (out_busy),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   assign out_busy = busy_force | (busy_cnt != 0);

   // Serializer model and pulse monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (out_we) begin
         got_q.push_back(out_d);
         pulse_cyc_q.push_back(cyc);
         if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
         last_pulse = cyc;
         busy_cnt <= busy_len;
      end else if (busy_clr) begin
         busy_cnt <= 0;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      in_w = 1'b1;
      in_d = b;
      step();
      in_w = 1'b0;
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         step();
         k++;
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      pulse_cyc_q.delete();
      last_pulse = -1000000;
      min_gap = 1000000;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_w = 1'b0;
      in_d = 8'h00;
      step();
      step();
      checks++; if (out_we !== 1'b0) begin errors++; $display("FAIL reset_out_we: got %b expected 0", out_we); end
      checks++; if (out_d !== 8'h00) begin errors++; $display("FAIL reset_out_d: got %h expected 00", out_d); end
      checks++; if (in_busy !== 1'b0) begin errors++; $display("FAIL reset_in_busy: got %b expected 0", in_busy); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      int pc;
      clear_mon();
      busy_len = 0;
      pc = cyc;
      push_byte(8'h41);
      wait_pulses(1, 20);
      step(); step(); step();
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", got_q[0]); end
         checks++; if (pulse_cyc_q[0] !== pc + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", pulse_cyc_q[0] - pc, 2); end
      end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level: got %0d expected 0", level); end
      checks++; if (out_d !== 8'h41) begin errors++; $display("FAIL single_out_d_hold: got %h expected 41", out_d); end
   endtask

   task automatic test_burst();
      clear_mon();
      busy_len = 4170;
      busy_force = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL burst_level_full: got %0d expected 16", level); end
      checks++; if (in_busy !== 1'b1) begin errors++; $display("FAIL burst_in_busy: got %b expected 1", in_busy); end
      busy_force = 1'b0;
      wait_pulses(1, 20);
      checks++; if (in_busy !== 1'b0) begin errors++; $display("FAIL burst_in_busy_fall: got %b expected 0", in_busy); end
      checks++; if (level !== 5'd15) begin errors++; $display("FAIL burst_level_after_pop: got %0d expected 15", level); end
      wait_pulses(16, 16 * 4200);
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL burst_count: got %0d expected 16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== 8'(8'h30 + i)) begin errors++; $display("FAIL burst_order[%0d]: got %h expected %h", i, got_q[i], 8'(8'h30 + i)); end
      end
      checks++; if (min_gap < 3) begin errors++; $display("FAIL burst_min_gap: got %0d expected >=3", min_gap); end
      busy_clr = 1'b1;
      step();
      busy_clr = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      clear_mon();
      busy_len = 5;
      busy_force = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
      checks++; if (in_busy !== 1'b1) begin errors++; $display("FAIL ovf_in_busy: got %b expected 1", in_busy); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
      push_byte(8'h55);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
      busy_force = 1'b0;
      wait_pulses(16, 400);
      for (int i = 0; i < 20; i++) step();
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== 8'(8'h60 + i)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, got_q[i], 8'(8'h60 + i)); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", level); end
   endtask

   task automatic test_simul();
      int k = 0;
      clear_mon();
      busy_len = 0;
      busy_force = 1'b1;
      for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i));
      checks++; if (level !== 5'd5) begin errors++; $display("FAIL simul_level_pre: got %0d expected 5", level); end
      busy_force = 1'b0;
      while (out_we !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      checks++; if (out_we !== 1'b1) begin errors++; $display("FAIL simul_send_seen: got %b expected 1", out_we); end
      push_byte(8'hA5);
      checks++; if (level !== 5'd5) begin errors++; $display("FAIL simul_level: got %0d expected 5", level); end
      wait_pulses(6, 100);
      checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL simul_count: got %0d expected 6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== 8'(8'hA0 + i)) begin errors++; $display("FAIL simul_order[%0d]: got %h expected %h", i, got_q[i], 8'(8'hA0 + i)); end
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      clear_mon();
      busy_len = 0;
      busy_force = 1'b1;
      push_byte(8'hEE);
      for (int i = 0; i < 16; i++) push_byte(8'(8'h70 + i));
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rstmid_ovf_set: got %b expected 1", overflow); end
      busy_force = 1'b0;
      while (level !== 5'd7 && k < 200) begin
         step();
         k++;
      end
      checks++; if (level !== 5'd7) begin errors++; $display("FAIL rstmid_level_pre: got %0d expected 7", level); end
      rst = 1'b1;
      step();
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", level); end
      checks++; if (out_we !== 1'b0) begin errors++; $display("FAIL rstmid_out_we: got %b expected 0", out_we); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b expected 0", overflow); end
      checks++; if (in_busy !== 1'b0) begin errors++; $display("FAIL rstmid_in_busy: got %b expected 0", in_busy); end
      rst = 1'b0;
      clear_mon();
      for (int i = 0; i < 40; i++) step();
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_pulses: got %0d expected 0", got_q.size()); end
   endtask

   task automatic test_crlf();
      logic [7:0] exp[3];
      int         n;
      clear_mon();
      busy_len = 0;
      busy_force = 1'b0;
      exp[0] = 8'h48;
`ifdef RS232OUT_FIFO_CRLF_EN
      exp[1] = 8'h0D;
      exp[2] = 8'h0A;
      n = 3;
`else
      exp[1] = 8'h0A;
      exp[2] = 8'h00;
      n = 2;
`endif
      push_byte(8'h48);
      push_byte(8'h0A);
      wait_pulses(n, 60);
      for (int i = 0; i < 10; i++) step();
      checks++; if (got_q.size() !== n) begin errors++; $display("FAIL crlf_count: got %0d expected %0d", got_q.size(), n); end
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL crlf_seq[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
      end
      checks++; if (min_gap !== 3) begin errors++; $display("FAIL crlf_min_gap: got %0d expected 3", min_gap); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL crlf_level: got %0d expected 0", level); end
   endtask

   initial begin
      rst = 1'b1;
      in_w = 1'b0;
      in_d = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_simul();
      test_reset_mid();
      test_crlf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
